// File: rtl/sky130_as_sc_hs__sdfrpipe_if.sv
// Data, valid, enable and scan signals of the sdfrpipe macro, grouped for port connection.
// The driver side uses master; the pipeline itself uses slave.
`timescale 1ns/1ps
interface sky130_as_sc_hs__sdfrpipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] D;
  logic             DV;
  logic             DE;
  logic             SCE;
  logic             SCD;
  logic [WIDTH-1:0] Q;
  logic             QV;
  logic             SCQ;

  modport master (
    output D, DV, DE, SCE, SCD,
    input  Q, QV, SCQ
  );

  modport slave (
    input  D, DV, DE, SCE, SCD,
    output Q, QV, SCQ
  );
endinterface

// File: rtl/sky130_as_sc_hs__sdfrpipe.sv
// WIDTH x DEPTH enabled register pipeline with a travelling valid bit, asynchronous reset
// to RESET_VAL and one scan chain through every data bit. Power pins are ports only.
`timescale 1ns/1ps
module sky130_as_sc_hs__sdfrpipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                        CLK,
  input logic                        RESET,
  sky130_as_sc_hs__sdfrpipe_if.slave bus,
  input logic                        VPWR,
  input logic                        VGND,
  input logic                        VPB,
  input logic                        VNB
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("sky130_as_sc_hs__sdfrpipe: WIDTH must be 1..64");
  end
  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("sky130_as_sc_hs__sdfrpipe: DEPTH must be 1..16");
  end

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] scan_in;

  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    scan_in = '0;
    // Each stage's bit 0 is fed by the MSB of the stage before it, so the chain is continuous.
    scan_in[0] = bus.SCD;
    for (int unsigned s = 1; s < DEPTH; s++) begin
      scan_in[s] = stage_q[s-1][WIDTH-1];
    end
    if (bus.SCE) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        stage_d[s] = (stage_q[s] << 1) | WIDTH'(scan_in[s]);
      end
    end else if (bus.DE) begin
      stage_d[0] = bus.D;
      valid_d[0] = bus.DV;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        stage_d[s] = stage_q[s-1];
        valid_d[s] = valid_q[s-1];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        stage_q[s] <= RESET_VAL;
      end
      valid_q <= '0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Q   = stage_q[DEPTH-1];
  assign bus.QV  = valid_q[DEPTH-1];
  assign bus.SCQ = stage_q[DEPTH-1][WIDTH-1];

endmodule
